// File: rtl/hazard_unit_mc.sv
// Hazard unit for a 5-stage pipeline with a multi-cycle mul/div unit.
// It produces forwarding selects, load-use and mul/div stalls, branch flushes and stall/flush performance counters.
module hazard_unit_mc #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ResultSrcE,
    input  logic              MulDivE,
    input  logic              MdDone,
    input  logic              PcSrcE,
    input  logic              CntClr,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              MdStart,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
);

    typedef enum logic {IDLE, BUSY} md_state_t;

    md_state_t  state, state_nx;
    logic [1:0] ldCnt;
    logic       lwHit, ldStall, mdStall;
    logic       unused;

    // Execute-stage write enable plays no part in any hazard decision.
    assign unused = RegWriteE;

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (RegWriteM && rs != '0 && rs == RdM)      return 2'b10;
        else if (RegWriteW && rs != '0 && rs == RdW) return 2'b01;
        else                                         return 2'b00;
    endfunction

    assign ForwardAE = fwd_sel(Rs1E);
    assign ForwardBE = fwd_sel(Rs2E);

    assign lwHit   = ResultSrcE && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE)) && !PcSrcE;
    assign ldStall = lwHit || (ldCnt != 2'd0);
    assign mdStall = MulDivE && !((state == BUSY) && MdDone);

    // mul/div stall overrides every flush except FlushM (protocol violation vs. branch).
    always_comb begin
        state_nx = state;
        MdStart  = 1'b0;
        case (state)
            IDLE: if (MulDivE) begin
                state_nx = BUSY;
                MdStart  = 1'b1;
            end
            BUSY: if (MdDone) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        stallF = ldStall || mdStall;
        stallD = ldStall || mdStall;
        stallE = mdStall;
        FlushM = mdStall;
        FlushE = !mdStall && (ldStall || PcSrcE);
        FlushD = !mdStall && PcSrcE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ldCnt <= 2'd0;
        end else begin
            state <= state_nx;
            if (lwHit)               ldCnt <= 2'(LOAD_LAT - 1);
            else if (ldCnt != 2'd0)  ldCnt <= ldCnt - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else if (CntClr) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (stallF && StallCnt != '1) StallCnt <= StallCnt + 1'b1;
            if (PcSrcE && FlushCnt != '1) FlushCnt <= FlushCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench: two hazard_unit_mc instances (LOAD_LAT=3/CNT_W=16 and LOAD_LAT=1/CNT_W=2)
// driven by shared stimulus and compared every cycle against a behavioural model.
module tb_hazard_unit_mc;

    logic clk = 1'b0;
    logic reset;
    logic RegWriteE, RegWriteM, RegWriteW, ResultSrcE, MulDivE, MdDone, PcSrcE, CntClr;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;

    logic sFa, sDa, sEa, fDa, fEa, fMa, mSa;
    logic sFb, sDb, sEb, fDb, fEb, fMb, mSb;
    logic [1:0] fAa, fBa, fAb, fBb;
    logic [15:0] scA, fcA;
    logic [1:0]  scB, fcB;
    logic [10:0] ctl_a, ctl_b;

    int n_chk = 0;
    int n_fail = 0;

    bit     m_busy;
    int     m_ld[2];
    longint m_sc[2], m_fc[2];

    always #5 clk = ~clk;

    hazard_unit_mc #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .MulDivE(MulDivE), .MdDone(MdDone), .PcSrcE(PcSrcE), .CntClr(CntClr),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .stallF(sFa), .stallD(sDa), .stallE(sEa), .FlushD(fDa), .FlushE(fEa), .FlushM(fMa),
        .ForwardAE(fAa), .ForwardBE(fBa), .MdStart(mSa), .StallCnt(scA), .FlushCnt(fcA));

    hazard_unit_mc #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .MulDivE(MulDivE), .MdDone(MdDone), .PcSrcE(PcSrcE), .CntClr(CntClr),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .stallF(sFb), .stallD(sDb), .stallE(sEb), .FlushD(fDb), .FlushE(fEb), .FlushM(fMb),
        .ForwardAE(fAb), .ForwardBE(fBb), .MdStart(mSb), .StallCnt(scB), .FlushCnt(fcB));

    assign ctl_a = {sFa, sDa, sEa, fDa, fEa, fMa, fAa, fBa, mSa};
    assign ctl_b = {sFb, sDb, sEb, fDb, fEb, fMb, fAb, fBb, mSb};

    function automatic int lat(input int k);
        return (k == 0) ? 3 : 1;
    endfunction

    function automatic longint cmax(input int k);
        return (k == 0) ? 65535 : 3;
    endfunction

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (RegWriteM && rs != 0 && rs == RdM) return 2;
        if (RegWriteW && rs != 0 && rs == RdW) return 1;
        return 0;
    endfunction

    // Expected control vector, same packing as ctl_a/ctl_b.
    function automatic logic [10:0] exp_ctl(input int k);
        bit lw, ld, md, st;
        lw = ResultSrcE && RdE != 0 && (Rs1D == RdE || Rs2D == RdE) && !PcSrcE;
        ld = lw || (m_ld[k] > 0);
        md = MulDivE && !(m_busy && MdDone);
        st = ld || md;
        return {st, st, md, !md && PcSrcE, !md && (ld || PcSrcE), md,
                fwd(Rs1E), fwd(Rs2E), !m_busy && MulDivE};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_busy = 0;
        for (int k = 0; k < 2; k++) begin
            m_ld[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        if (!reset) model_clear();
        chk("ctl_a", ctl_a, exp_ctl(0));
        chk("ctl_b", ctl_b, exp_ctl(1));
        chk("stallcnt_a", scA, m_sc[0]);
        chk("flushcnt_a", fcA, m_fc[0]);
        chk("stallcnt_b", scB, m_sc[1]);
        chk("flushcnt_b", fcB, m_fc[1]);
    endtask

    task automatic adv();
        logic [10:0] e;
        bit lw;
        @(posedge clk);
        if (!reset) model_clear();
        else begin
            lw = ResultSrcE && RdE != 0 && (Rs1D == RdE || Rs2D == RdE) && !PcSrcE;
            for (int k = 0; k < 2; k++) begin
                e = exp_ctl(k);
                if (CntClr) begin
                    m_sc[k] = 0; m_fc[k] = 0;
                end else begin
                    if (e[10] && m_sc[k] < cmax(k)) m_sc[k]++;
                    if (PcSrcE && m_fc[k] < cmax(k)) m_fc[k]++;
                end
                if (lw) m_ld[k] = lat(k) - 1;
                else if (m_ld[k] > 0) m_ld[k]--;
            end
            if (!m_busy && MulDivE) m_busy = 1;
            else if (m_busy && MdDone) m_busy = 0;
        end
        #1;
    endtask

    task automatic tick();
        settle();
        adv();
    endtask

    task automatic zero_inputs();
        {RegWriteE, RegWriteM, RegWriteW, ResultSrcE, MulDivE, MdDone, PcSrcE, CntClr} = '0;
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    endtask

    initial begin
        int st_cnt, ms_cnt;
        reset = 1'b0;
        zero_inputs();
        model_clear();

        // Reset state with all inputs zero.
        settle();
        chk("rst_ctl_a", ctl_a, 0);
        chk("rst_ctl_b", ctl_b, 0);
        chk("rst_stallcnt", scA, 0);
        adv();
        reset = 1'b1;
        tick();

        // Memory forwarding beats Writeback; x0 never forwards.
        RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; Rs2E = 0;
        settle();
        chk("fwdA_mem", fAa, 2'b10);
        chk("fwdB_x0", fBa, 2'b00);
        adv();
        zero_inputs();
        RegWriteW = 1; RdW = 3; Rs2E = 3;
        settle();
        chk("fwdB_wb", fBa, 2'b01);
        adv();

        // Load-use, LOAD_LAT=3 on dut_a and 1 on dut_b.
        zero_inputs(); CntClr = 1; tick();
        CntClr = 0; ResultSrcE = 1; RdE = 7; Rs2D = 7;
        st_cnt = 0;
        settle(); st_cnt += int'(sFa && sDa && fEa); adv();
        zero_inputs();
        for (int i = 0; i < 3; i++) begin
            settle(); st_cnt += int'(sFa && sDa && fEa); adv();
        end
        chk("ld_stall_cycles_a", st_cnt, 3);
        chk("ld_stallcnt_a", scA, 3);
        chk("ld_stallcnt_b", scB, 1);

        // Load into x0 never stalls.
        ResultSrcE = 1; RdE = 0; Rs1D = 0;
        settle();
        chk("ld_x0_stall", sFa, 0);
        adv();
        zero_inputs();

        // mul/div with MdDone on the sixth cycle it is held.
        MulDivE = 1; st_cnt = 0; ms_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            MdDone = (i == 5);
            settle();
            st_cnt += int'(sEa && fMa);
            ms_cnt += int'(mSa);
            adv();
        end
        zero_inputs();
        chk("md_stall_cycles", st_cnt, 5);
        chk("md_start_pulses", ms_cnt, 1);
        MulDivE = 1;
        settle();
        chk("md_back_idle", mSa, 1);
        MulDivE = 0;
        settle();
        adv();

        // Branch flush with a saturated 2-bit counter on dut_b.
        zero_inputs(); CntClr = 1; tick();
        CntClr = 0; PcSrcE = 1;
        for (int i = 0; i < 3; i++) tick();
        chk("flushcnt_pre_b", fcB, 3);
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("br_flushD", fDb, 1);
            chk("br_flushE", fEb, 1);
            adv();
        end
        chk("flushcnt_sat_b", fcB, 3);
        chk("flushcnt_a", fcA, 5);
        zero_inputs();

        // Reset mid-BUSY, then a stale MdDone.
        MulDivE = 1; tick(); tick();
        reset = 0;
        settle();
        adv();
        reset = 1; MulDivE = 0; MdDone = 1;
        settle();
        chk("stale_done_ctl", ctl_a, 0);
        adv();
        MdDone = 0; MulDivE = 1;
        settle();
        chk("after_rst_idle", mSa, 1);
        adv();
        zero_inputs();

        // Randomized traffic over a small register set to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 199) != 0);
            RegWriteE  = 1'($urandom);
            RegWriteM  = 1'($urandom);
            RegWriteW  = 1'($urandom);
            ResultSrcE = ($urandom_range(0, 3) == 0);
            MulDivE    = ($urandom_range(0, 5) == 0) ? ~MulDivE : MulDivE;
            MdDone     = ($urandom_range(0, 3) == 0);
            PcSrcE     = ($urandom_range(0, 5) == 0);
            CntClr     = ($urandom_range(0, 63) == 0);
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
